// File: rtl/dm_port_arbiter_if.sv
// Bundle of requester handshakes (ports 0/1) and the data-memory bus.
// slave = arbiter side, master = requesters plus DM side.
interface dm_port_arbiter_if #(
  parameter int ADDR_W = 10
);
  logic              p0_req;
  logic              p0_we;
  logic [31:0]       p0_addr;
  logic [1:0]        p0_type;
  logic              p0_unsigned;
  logic [31:0]       p0_wdata;
  logic              p0_gnt;
  logic              p0_rvalid;
  logic [31:0]       p0_rdata;
  logic              p0_err;

  logic              p1_req;
  logic              p1_we;
  logic [31:0]       p1_addr;
  logic [1:0]        p1_type;
  logic              p1_unsigned;
  logic [31:0]       p1_wdata;
  logic              p1_gnt;
  logic              p1_rvalid;
  logic [31:0]       p1_rdata;
  logic              p1_err;

  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_type, p0_unsigned, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata, p0_err,
    input  p1_req, p1_we, p1_addr, p1_type, p1_unsigned, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata, p1_err,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_type, p0_unsigned, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
    output p1_req, p1_we, p1_addr, p1_type, p1_unsigned, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dm_port_arbiter.sv
// Two-port round-robin sequencer for a 1-cycle-latency word-wide data memory.
// Optional performance counters: define DM_PORT_ARBITER_PERF_EN.
module dm_port_arbiter #(
  parameter int ADDR_W = 10
) (
  input  logic clk,
  input  logic reset,
  dm_port_arbiter_if.slave bus
`ifdef DM_PORT_ARBITER_PERF_EN
  ,
  output logic [31:0] perf_p0_cnt,
  output logic [31:0] perf_p1_cnt,
  output logic [31:0] perf_conflict_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t            state, state_n;
  logic              rr;
  logic              owner;
  logic              grant;
  logic              win;

  logic              l_we;
  logic              l_uns;
  logic [1:0]        l_type;
  logic [ADDR_W+1:0] l_addr;
  logic [31:0]       l_wdata;

  logic              l_bad;
  logic              issue;
  logic [3:0]        st_be;
  logic [31:0]       st_data;
  logic [15:0]       ld_half;
  logic [7:0]        ld_byte;
  logic [31:0]       ld_data;
  logic [31:0]       result;

  logic              unused_addr_hi;
  assign unused_addr_hi = ^{bus.p0_addr[31:ADDR_W+2], bus.p1_addr[31:ADDR_W+2]};

  always_comb begin
    state_n = state;
    grant   = 1'b0;
    win     = 1'b0;
    case (state)
      IDLE: begin
        if (!reset && (bus.p0_req || bus.p1_req)) begin
          grant   = 1'b1;
          win     = (bus.p0_req && bus.p1_req) ? rr : bus.p1_req;
          state_n = ISSUE;
        end
      end
      ISSUE:   state_n = WAIT;
      WAIT:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.p0_gnt = grant & ~win;
  assign bus.p1_gnt = grant & win;

  assign l_bad = (l_type == 2'b11) ||
                 (l_type == 2'b00 && l_addr[1:0] != 2'b00) ||
                 (l_type == 2'b01 && l_addr[0]);

  always_comb begin
    st_be   = '0;
    st_data = l_wdata;
    case (l_type)
      2'b00: st_be = 4'b1111;
      2'b01: begin
        st_be   = l_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{l_wdata[15:0]}};
      end
      2'b10: begin
        st_be   = 4'b0001 << l_addr[1:0];
        st_data = {4{l_wdata[7:0]}};
      end
      default: st_be = '0;
    endcase
  end

  assign issue         = (state == ISSUE) && !l_bad;
  assign bus.mem_en    = issue;
  assign bus.mem_we    = (issue && l_we) ? st_be : '0;
  assign bus.mem_addr  = issue ? l_addr[ADDR_W+1:2] : '0;
  assign bus.mem_wdata = (issue && l_we) ? st_data : '0;

  always_comb begin
    ld_half = l_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    ld_byte = bus.mem_rdata[7:0];
    case (l_addr[1:0])
      2'd0:    ld_byte = bus.mem_rdata[7:0];
      2'd1:    ld_byte = bus.mem_rdata[15:8];
      2'd2:    ld_byte = bus.mem_rdata[23:16];
      default: ld_byte = bus.mem_rdata[31:24];
    endcase
    ld_data = bus.mem_rdata;
    case (l_type)
      2'b01:   ld_data = {{16{~l_uns & ld_half[15]}}, ld_half};
      2'b10:   ld_data = {{24{~l_uns & ld_byte[7]}}, ld_byte};
      default: ld_data = bus.mem_rdata;
    endcase
    result = (l_bad || l_we) ? '0 : ld_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      rr            <= 1'b0;
      owner         <= 1'b0;
      l_we          <= 1'b0;
      l_uns         <= 1'b0;
      l_type        <= '0;
      l_addr        <= '0;
      l_wdata       <= '0;
      bus.p0_rvalid <= 1'b0;
      bus.p0_err    <= 1'b0;
      bus.p0_rdata  <= '0;
      bus.p1_rvalid <= 1'b0;
      bus.p1_err    <= 1'b0;
      bus.p1_rdata  <= '0;
    end else begin
      state <= state_n;
      if (grant) begin
        owner   <= win;
        rr      <= ~win;
        l_we    <= win ? bus.p1_we       : bus.p0_we;
        l_uns   <= win ? bus.p1_unsigned : bus.p0_unsigned;
        l_type  <= win ? bus.p1_type     : bus.p0_type;
        l_addr  <= win ? bus.p1_addr[ADDR_W+1:0] : bus.p0_addr[ADDR_W+1:0];
        l_wdata <= win ? bus.p1_wdata    : bus.p0_wdata;
      end
      // Response registers of the non-owner keep their rdata and stay idle.
      bus.p0_rvalid <= (state == WAIT) && !owner;
      bus.p0_err    <= (state == WAIT) && !owner && l_bad;
      bus.p1_rvalid <= (state == WAIT) && owner;
      bus.p1_err    <= (state == WAIT) && owner && l_bad;
      if (state == WAIT && !owner) bus.p0_rdata <= result;
      if (state == WAIT && owner)  bus.p1_rdata <= result;
    end
  end

`ifdef DM_PORT_ARBITER_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_p0_cnt       <= '0;
      perf_p1_cnt       <= '0;
      perf_conflict_cnt <= '0;
    end else begin
      if (bus.p0_gnt) perf_p0_cnt <= perf_p0_cnt + 32'd1;
      if (bus.p1_gnt) perf_p1_cnt <= perf_p1_cnt + 32'd1;
      if (state == IDLE && bus.p0_req && bus.p1_req)
        perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: directed scenarios plus random traffic checked
// cycle by cycle against a transaction-level reference model.
module tb_dm_port_arbiter;
  localparam int ADDR_W = 10;

  logic clk = 1'b0;
  logic rst;
  logic dm_clr;
  always #5 clk = ~clk;

  dm_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef DM_PORT_ARBITER_PERF_EN
  logic [31:0] perf_p0_cnt, perf_p1_cnt, perf_conflict_cnt;
`endif

  dm_port_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
`ifdef DM_PORT_ARBITER_PERF_EN
    ,
    .perf_p0_cnt       (perf_p0_cnt),
    .perf_p1_cnt       (perf_p1_cnt),
    .perf_conflict_cnt (perf_conflict_cnt)
`endif
  );

  // Synchronous DM, 1-cycle read latency.
  logic [31:0] dm [0:1023];
  always @(posedge clk) begin
    if (dm_clr) begin
      for (int i = 0; i < 1024; i++) dm[i] <= '0;
      bus.mem_rdata <= '0;
    end else if (bus.mem_en) begin
      bus.mem_rdata <= dm[bus.mem_addr];
      for (int l = 0; l < 4; l++)
        if (bus.mem_we[l]) dm[bus.mem_addr][8*l +: 8] <= bus.mem_wdata[8*l +: 8];
    end
  end

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  bit hold     = 1'b0;

  // Reference model: an access occupies 3 cycles from grant; response at grant+3.
  logic [31:0] ref_mem [0:1023];
  bit          m_act;
  int          m_gc;
  int          m_owner;
  int          m_pref;
  bit          m_err;
  bit          m_issue;
  logic [31:0] m_data;
  logic [3:0]  m_we;
  logic [9:0]  m_idx;
  logic [31:0] m_wd;
  logic [31:0] exp_rd [2];

  bit          g_obs [2];
  bit          rv_seen [2];
  int          lg_cyc [2];
  int          lr_cyc [2];
  logic [31:0] lr_data [2];
  logic        lr_err [2];
  logic [9:0]  lm_addr;
  logic [3:0]  lm_we;
  logic [31:0] lm_wd;
  int          n_memen = 0;
  bit          all_zero;
  int          gq_port [$];
  int          gq_cyc [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic we, input logic [31:0] a,
                       input logic [1:0] t, input logic u, input logic [31:0] wd);
    if (p == 0) begin
      bus.p0_we = we; bus.p0_addr = a; bus.p0_type = t;
      bus.p0_unsigned = u; bus.p0_wdata = wd; bus.p0_req = 1'b1;
    end else begin
      bus.p1_we = we; bus.p1_addr = a; bus.p1_type = t;
      bus.p1_unsigned = u; bus.p1_wdata = wd; bus.p1_req = 1'b1;
    end
  endtask

  task automatic model_grant(input int p);
    logic        we, u;
    logic [1:0]  t;
    logic [31:0] a, wd, w, v;
    we = (p == 0) ? bus.p0_we       : bus.p1_we;
    u  = (p == 0) ? bus.p0_unsigned : bus.p1_unsigned;
    t  = (p == 0) ? bus.p0_type     : bus.p1_type;
    a  = (p == 0) ? bus.p0_addr     : bus.p1_addr;
    wd = (p == 0) ? bus.p0_wdata    : bus.p1_wdata;
    m_act = 1'b1; m_gc = cyc; m_owner = p; m_pref = 1 - p;
    m_idx   = a[11:2];
    m_err   = (t == 2'd3) || (t == 2'd0 && a[1:0] != 2'd0) || (t == 2'd1 && a[0]);
    m_issue = !m_err;
    m_we = '0; m_wd = '0; m_data = '0;
    if (!m_err && we) begin
      case (t)
        2'd0:    begin m_we = 4'hF; m_wd = wd; end
        2'd1:    begin m_we = a[1] ? 4'hC : 4'h3; m_wd = (wd & 32'hFFFF) * 32'h0001_0001; end
        default: begin m_we = 4'(1 << a[1:0]); m_wd = (wd & 32'hFF) * 32'h0101_0101; end
      endcase
      w = ref_mem[m_idx];
      for (int l = 0; l < 4; l++) if (m_we[l]) w[8*l +: 8] = m_wd[8*l +: 8];
      ref_mem[m_idx] = w;
    end else if (!m_err) begin
      w = ref_mem[m_idx];
      case (t)
        2'd0: v = w;
        2'd1: begin
          v = (w >> (16 * a[1])) & 32'hFFFF;
          if (!u && v[15]) v = v | 32'hFFFF_0000;
        end
        default: begin
          v = (w >> (8 * a[1:0])) & 32'hFF;
          if (!u && v[7]) v = v | 32'hFFFF_FF00;
        end
      endcase
      m_data = v;
    end
  endtask

  task automatic tick();
    logic       r0, r1, eg0, eg1, emen;
    logic [3:0] ewe;
    logic       erv [2];
    logic       eer [2];
    int         win;
    @(negedge clk);
    r0 = bus.p0_req; r1 = bus.p1_req;
    erv[0] = 1'b0; erv[1] = 1'b0; eer[0] = 1'b0; eer[1] = 1'b0;
    if (m_act && cyc == m_gc + 3) begin
      erv[m_owner] = 1'b1;
      eer[m_owner] = m_err;
      exp_rd[m_owner] = m_data;
      m_act = 1'b0;
    end
    emen = m_act && cyc == m_gc + 1 && m_issue;
    ewe  = emen ? m_we : 4'h0;
    eg0 = 1'b0; eg1 = 1'b0; win = 0;
    if (!rst && !m_act && (r0 || r1)) begin
      win = (r0 && r1) ? m_pref : (r1 ? 1 : 0);
      eg0 = (win == 0);
      eg1 = (win == 1);
    end
    chk("p0_gnt",    32'(bus.p0_gnt),    32'(eg0));
    chk("p1_gnt",    32'(bus.p1_gnt),    32'(eg1));
    chk("p0_rvalid", 32'(bus.p0_rvalid), 32'(erv[0]));
    chk("p1_rvalid", 32'(bus.p1_rvalid), 32'(erv[1]));
    chk("p0_err",    32'(bus.p0_err),    32'(eer[0]));
    chk("p1_err",    32'(bus.p1_err),    32'(eer[1]));
    chk("p0_rdata",  bus.p0_rdata,       exp_rd[0]);
    chk("p1_rdata",  bus.p1_rdata,       exp_rd[1]);
    chk("mem_en",    32'(bus.mem_en),    32'(emen));
    chk("mem_we",    32'(bus.mem_we),    32'(ewe));
    if (emen) begin
      chk("mem_addr", 32'(bus.mem_addr), 32'(m_idx));
      if (m_we != 4'h0) chk("mem_wdata", bus.mem_wdata, m_wd);
    end
    g_obs[0] = bus.p0_gnt; g_obs[1] = bus.p1_gnt;
    if (bus.p0_gnt) begin gq_port.push_back(0); gq_cyc.push_back(cyc); lg_cyc[0] = cyc; end
    if (bus.p1_gnt) begin gq_port.push_back(1); gq_cyc.push_back(cyc); lg_cyc[1] = cyc; end
    if (bus.mem_en) begin
      n_memen++; lm_addr = bus.mem_addr; lm_we = bus.mem_we; lm_wd = bus.mem_wdata;
    end
    if (bus.p0_rvalid) begin rv_seen[0] = 1'b1; lr_cyc[0] = cyc; lr_data[0] = bus.p0_rdata; lr_err[0] = bus.p0_err; end
    if (bus.p1_rvalid) begin rv_seen[1] = 1'b1; lr_cyc[1] = cyc; lr_data[1] = bus.p1_rdata; lr_err[1] = bus.p1_err; end
    all_zero = ({bus.p0_gnt, bus.p0_rvalid, bus.p0_err, bus.p0_rdata,
                 bus.p1_gnt, bus.p1_rvalid, bus.p1_err, bus.p1_rdata,
                 bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} == '0);
    if (eg0 || eg1) model_grant(win);
    if (rst) begin
      m_act = 1'b0; m_pref = 0; exp_rd[0] = '0; exp_rd[1] = '0;
    end
    cyc++;
    @(posedge clk);
    #1;
    if (!hold) begin
      if (g_obs[0]) bus.p0_req = 1'b0;
      if (g_obs[1]) bus.p1_req = 1'b0;
    end
  endtask

  task automatic acc(input int p, input logic we, input logic [31:0] a,
                     input logic [1:0] t, input logic u, input logic [31:0] wd);
    drive(p, we, a, t, u, wd);
    rv_seen[p] = 1'b0;
    for (int i = 0; i < 12 && !rv_seen[p]; i++) tick();
    chk("acc_done", 32'(rv_seen[p]), 32'd1);
    tick();
  endtask

  initial begin
    int t0;
    int n0;
    rst = 1'b1; dm_clr = 1'b1;
    bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = '0; bus.p0_type = '0; bus.p0_unsigned = 0; bus.p0_wdata = '0;
    bus.p1_req = 0; bus.p1_we = 0; bus.p1_addr = '0; bus.p1_type = '0; bus.p1_unsigned = 0; bus.p1_wdata = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    m_act = 0; m_pref = 0; exp_rd[0] = '0; exp_rd[1] = '0;
    tick(); tick();
    dm_clr = 1'b0; rst = 1'b0;
    tick();
    chk("reset_zero", 32'(all_zero), 32'd1);

    // Word store then sub-word loads of the same word.
    acc(0, 1'b1, 32'h0000_0010, 2'b00, 1'b0, 32'hDEAD_BEEF);
    chk("st_w_addr", 32'(lm_addr), 32'd4);
    chk("st_w_we",   32'(lm_we),   32'hF);
    chk("st_w_lat",  32'(lr_cyc[0] - lg_cyc[0]), 32'd3);
    chk("st_w_err",  32'(lr_err[0]), 32'd0);
    acc(1, 1'b0, 32'h0000_0013, 2'b10, 1'b0, '0);
    chk("ld_b_s",    lr_data[1], 32'hFFFF_FFDE);
    acc(1, 1'b0, 32'h0000_0013, 2'b10, 1'b1, '0);
    chk("ld_b_u",    lr_data[1], 32'h0000_00DE);
    acc(1, 1'b0, 32'h0000_0012, 2'b01, 1'b0, '0);
    chk("ld_h_s",    lr_data[1], 32'hFFFF_DEAD);

    // Upper-half store; low half must survive.
    acc(0, 1'b1, 32'h0000_0006, 2'b01, 1'b0, 32'h1234_ABCD);
    chk("st_h_we",   32'(lm_we), 32'hC);
    chk("st_h_wd",   lm_wd, 32'hABCD_ABCD);
    acc(0, 1'b0, 32'h0000_0004, 2'b00, 1'b0, '0);
    chk("ld_w_mrg",  lr_data[0], 32'hABCD_0000);

    // Misaligned and illegal accesses never touch the DM.
    n0 = n_memen;
    acc(0, 1'b0, 32'h0000_0002, 2'b00, 1'b0, '0);
    chk("mis_w_err", 32'(lr_err[0]), 32'd1);
    chk("mis_w_rd",  lr_data[0], 32'd0);
    acc(1, 1'b0, 32'h0000_0005, 2'b01, 1'b0, '0);
    chk("mis_h_err", 32'(lr_err[1]), 32'd1);
    acc(0, 1'b1, 32'h0000_0008, 2'b11, 1'b0, 32'h5555_5555);
    chk("ill_err",   32'(lr_err[0]), 32'd1);
    chk("err_no_mem", 32'(n_memen - n0), 32'd0);

    // Both requesters held from reset: strict alternation every 3 cycles.
    rst = 1'b1;
    drive(0, 1'b0, 32'h0000_0010, 2'b00, 1'b0, '0);
    drive(1, 1'b0, 32'h0000_0013, 2'b10, 1'b0, '0);
    hold = 1'b1;
    tick();
    rst = 1'b0;
    t0 = cyc;
    gq_port.delete(); gq_cyc.delete();
    repeat (12) tick();
    chk("alt_count", 32'(gq_port.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < gq_port.size()) begin
        chk("alt_port", 32'(gq_port[i]), 32'(i % 2));
        chk("alt_cyc",  32'(gq_cyc[i]),  32'(t0 + 3 * i));
      end
    end
    hold = 1'b0;
    bus.p0_req = 1'b0; bus.p1_req = 1'b0;
    repeat (4) tick();

    // Reset during WAIT abandons the load.
    drive(0, 1'b0, 32'h0000_0010, 2'b00, 1'b0, '0);
    g_obs[0] = 1'b0;
    for (int i = 0; i < 10 && !g_obs[0]; i++) tick();
    chk("rw_gnt", 32'(g_obs[0]), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rv_seen[0] = 1'b0;
    tick();
    chk("rw_zero", 32'(all_zero), 32'd1);
    chk("rw_norv", 32'(rv_seen[0]), 32'd0);
    drive(0, 1'b0, 32'h0000_0004, 2'b00, 1'b0, '0);
    drive(1, 1'b0, 32'h0000_0010, 2'b01, 1'b1, '0);
    tick();
    chk("rw_pref", 32'(g_obs[0]), 32'd1);
    repeat (8) tick();

    // Random traffic on both ports.
    for (int s = 0; s < 400; s++) begin
      for (int p = 0; p < 2; p++) begin
        logic cur;
        logic [31:0] a;
        cur = (p == 0) ? bus.p0_req : bus.p1_req;
        if (!cur && $urandom_range(0, 1) == 1) begin
          if ($urandom_range(0, 7) == 0) a = 32'h0000_0FFC | 32'($urandom_range(0, 3));
          else a = 32'($urandom_range(0, 63));
          if ($urandom_range(0, 1) == 1) a = a | 32'h0010_0000;
          drive(p, 1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), $urandom);
        end
      end
      tick();
    end
    bus.p0_req = 1'b0; bus.p1_req = 1'b0;
    repeat (8) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Sequencer and arbiter for the shared data memory (DM) between two requesters: port 0 (CPU load/store unit) and port 1 (debug/DMA loader).
- Per access:
  - grants one requester by round-robin;
  - checks alignment;
  - generates word address, byte enables and lane-replicated store data;
  - returns sign- or zero-extended sub-word load data.
- Sits between the load/store stage and a synchronous word-wide DM with 1-cycle read latency.

Parameters:
ADDR_W, 10, DM word-address width (DM depth = 2^ADDR_W words)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
p0_req  input  1  port 0 request; held stable with its fields until p0_gnt
p0_we  input  1  1 = store, 0 = load
p0_addr  input  32  byte address
p0_type  input  2  00 word, 01 half, 10 byte, 11 illegal
p0_unsigned  input  1  load zero-extend (1) / sign-extend (0)
p0_wdata  input  32  store data, right-aligned
p0_gnt  output  1  request accepted this cycle
p0_rvalid  output  1  one-cycle completion pulse
p0_rdata  output  32  formatted load data; 0 for stores and errors
p0_err  output  1  valid with p0_rvalid: misaligned/illegal access
p1_*  same set as p0_*, for port 1
mem_en  output  1  DM access strobe
mem_we  output  4  byte write enables, bit i = byte lane i
mem_addr  output  ADDR_W  word address = addr[ADDR_W+1:2]
mem_wdata  output  32  lane-replicated store data
mem_rdata  input  32  DM read data, valid the cycle after mem_en

Behaviour:
- Reset (synchronous, active-high): state IDLE, rr pointer = port 0 preferred. All outputs 0: gnt, rvalid, rdata, err, mem_en, mem_we, mem_addr, mem_wdata.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE, any req:
  - one req: that port wins;
  - both reqs: the port named by the rr pointer wins.
  - Winner's gnt is asserted combinationally this cycle (T).
  - Request fields latched; rr pointer set to the other port; next state ISSUE.
  - No req: stay in IDLE.
- ISSUE (T+1):
  - Legal access: mem_en=1, mem_addr, mem_we and mem_wdata driven from the latched request.
  - Error access: mem_en=0, mem_we=0.
  - Next state WAIT.
- WAIT (T+2):
  - mem_rdata sampled and formatted.
  - At the clock edge, the owner's rvalid, rdata and err registers load; all are visible at T+3 for exactly one cycle.
  - Next state IDLE.
- Overall timing: gnt at T, rvalid at T+3.
- Overlap at T+3: a new grant may occur at T+3 while the previous rvalid is still high. Maximum rate is one access per 3 cycles.
- Non-owner port: its rvalid and err stay 0; its rdata holds its last value.
- Illegal / misaligned accesses (set err, no DM access, rdata=0):
  - type 11;
  - word with addr[1:0]!=0;
  - half with addr[0]!=0.
- Store encoding:
  - word: we=1111, wdata unchanged;
  - half: we=0011 if addr[1]=0, else 1100; wdata={2{wdata[15:0]}};
  - byte: we=0001<<addr[1:0]; wdata={4{wdata[7:0]}}.
- Store response: rvalid=1, rdata=0, err=0.
- Load extraction:
  - word: rdata=mem_rdata;
  - half: mem_rdata[31:16] if addr[1]=1, else [15:0]; extension bit is bit 15 of the selected half;
  - byte: lane addr[1:0]; extension bit is bit 7 of the selected byte;
  - extension is zero-fill when unsigned=1.
- Address bits above ADDR_W+1 are ignored (wrap-around within DM).
- req deasserted before gnt: no effect. gnt is never asserted outside IDLE.
- Reset mid-access (ISSUE/WAIT): access abandoned, no rvalid, FSM to IDLE. Any store already issued in ISSUE is not undone.

Optional Feature:
- Macro: DM_PORT_ARBITER_PERF_EN.
- Defined:
  - adds outputs perf_p0_cnt[31:0], perf_p1_cnt[31:0] and perf_conflict_cnt[31:0];
  - perf_p0_cnt / perf_p1_cnt increment on each grant to that port;
  - perf_conflict_cnt increments on each IDLE cycle with both reqs high;
  - all three reset to 0 and wrap at 2^32.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

Test Plan:
- p0 store word addr 0x0000_0010, wdata 0xDEADBEEF:
  - gnt at T;
  - ISSUE: mem_en=1, mem_addr=4, mem_we=1111;
  - p0_rvalid=1, err=0 at T+3.
- Load after that store:
  - p1 load byte addr 0x13, signed -> p1_rdata=0xFFFFFFDE;
  - same with unsigned=1 -> 0x000000DE;
  - p1 load half addr 0x12, signed -> 0xFFFFDEAD.
- p0 store half addr 0x06, wdata 0x1234ABCD:
  - mem_we=1100, mem_wdata=0xABCDABCD;
  - p0 load word addr 0x04 then returns 0xABCDxxxx, with low half unchanged.
- Both reqs held continuously from reset, loads:
  - grants alternate p0,p1,p0,p1 at T, T+3, T+6, T+9;
  - each rvalid arrives on its owner's port only.
- p0 load word addr 0x02 and p1 load half addr 0x05 (and one with type 11):
  - mem_en stays 0;
  - rvalid=1, err=1, rdata=0.
- Reset asserted during WAIT of a p0 load:
  - p0_rvalid never pulses;
  - FSM in IDLE next cycle;
  - all outputs 0;
  - next simultaneous request grants p0.
